reg_str: RTL and testbench

//   General-purpose WIDTH-bit data register with load, increment and clear.

---
 rtl/reg_str_pkg.sv | 5 +
 rtl/reg_str_next.sv | 25 ++
 rtl/reg_str.sv | 33 +++
 tb/tb_reg_str.sv | 105 ++++++++++
 4 files changed

// File: rtl/reg_str_pkg.sv
// reg_str_pkg: shared width default and operation encoding for the reg_str register
package reg_str_pkg;
  localparam int REG_STR_WIDTH_DEF = 32;
  typedef enum logic [1:0] {OP_HOLD, OP_LOAD, OP_INC, OP_CLR} reg_op_e;
endpackage

// File: rtl/reg_str_next.sv
// reg_str_next: next-value mux for reg_str (clear/increment/load/hold)
// ports: op (selected operation), cur (current value), inp (load word), nxt (next value)
// REG_STR_SAT_INC_EN: when defined the increment saturates at all-ones instead of wrapping
module reg_str_next
  import reg_str_pkg::*;
#(
  parameter int WIDTH = REG_STR_WIDTH_DEF
) (
  input  reg_op_e          op,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] inp,
  output logic [WIDTH-1:0] nxt
);
  logic [WIDTH-1:0] inc_val;
`ifdef REG_STR_SAT_INC_EN
  assign inc_val = &cur ? cur : cur + WIDTH'(1);
`else
  assign inc_val = cur + WIDTH'(1);
`endif
  always_comb begin
    nxt = op == OP_CLR  ? '0 :
          op == OP_INC  ? inc_val :
          op == OP_LOAD ? inp : cur;
  end
endmodule

// File: rtl/reg_str.sv
// reg_str: WIDTH-bit register with synchronous clear, increment and load
// ports: clk, rst_a (async active-low clear), rst_s (sync clear), inc (increment),
//        we (load enable), inp (load word), datadout (registered contents)
// REG_STR_SAT_INC_EN: selects a saturating increment in reg_str_next
module reg_str
  import reg_str_pkg::*;
#(
  parameter int WIDTH = REG_STR_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_a,
  input  logic             rst_s,
  input  logic             inc,
  input  logic             we,
  input  logic [WIDTH-1:0] inp,
  output logic [WIDTH-1:0] datadout
);
  reg_op_e          op;
  logic [WIDTH-1:0] nxt;
  always_comb begin
    op = rst_s ? OP_CLR : inc ? OP_INC : we ? OP_LOAD : OP_HOLD;
  end
  reg_str_next #(.WIDTH(WIDTH)) u_next (
    .op  (op),
    .cur (datadout),
    .inp (inp),
    .nxt (nxt)
  );
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) datadout <= '0;
    else        datadout <= nxt;
  end
endmodule

// File: tb/tb_reg_str.sv
// tb_reg_str: directed scoreboard bench for reg_str
module tb_reg_str;
  localparam int W = 32;
  logic         clk = 1'b0;
  logic         rst_a = 1'b0;
  logic         rst_s = 1'b0;
  logic         inc = 1'b0;
  logic         we = 1'b0;
  logic [W-1:0] inp = '0;
  logic [W-1:0] datadout;
  logic [W-1:0] q[$];
  logic [W-1:0] m = '0;
  int           total = 0;
  int           bad = 0;

  reg_str #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_a    (rst_a),
    .rst_s    (rst_s),
    .inc      (inc),
    .we       (we),
    .inp      (inp),
    .datadout (datadout)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [W-1:0] exp);
    total++;
    assert (datadout === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, datadout, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic rs, input logic i, input logic w,
                                         input logic [W-1:0] d, input logic [W-1:0] cur);
`ifdef REG_STR_SAT_INC_EN
    logic [W-1:0] iv = (cur == '1) ? cur : cur + 1;
`else
    logic [W-1:0] iv = cur + 1;
`endif
    return rs ? '0 : i ? iv : w ? d : cur;
  endfunction

  task automatic step(input string tag, input logic rs, input logic i, input logic w,
                      input logic [W-1:0] d);
    rst_s = rs; inc = i; we = w; inp = d;
    m = model(rs, i, w, d, m);
    q.push_back(m);
    @(posedge clk);
    #1;
    chk(tag, q.pop_front());
  endtask

  initial begin
    we = 1'b1; inp = 32'hA;
    @(posedge clk); #1;
    chk("rst_hold0", '0);
    inc = 1'bx; rst_s = 1'bx;
    @(posedge clk); #1;
    chk("rst_hold1_xctl", '0);
    inc = 1'b0; rst_s = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
    #1;
    chk("rst_release_pre_edge", '0);
    m = '0;
    step("first_load", 0, 0, 1, 32'hA);
    step("load5", 0, 0, 1, 32'd5);
    step("load7", 0, 0, 1, 32'd7);
    step("load12", 0, 0, 1, 32'd12);
    step("sclr_over_we", 1, 0, 1, 32'd9);
    step("load9", 0, 0, 1, 32'd9);
    for (int k = 0; k < 3; k++) step("hold", 0, 0, 0, $urandom);
    step("inc10", 0, 1, 1, 32'd3);
    step("inc11", 0, 1, 1, 32'd3);
    step("inc12", 0, 1, 1, 32'd3);
    step("sclr_over_inc", 1, 1, 1, 32'd3);
    step("load_ones", 0, 0, 1, 32'hFFFF_FFFF);
    step("inc_at_ones", 0, 1, 0, '0);
    step("inc_after_ones", 0, 1, 0, '0);
    step("load6", 0, 0, 1, 32'd6);
    step("inc7", 0, 1, 0, '0);
    inc = 1'b1; we = 1'b0;
    #3;
    rst_a = 1'b0;
    #1;
    chk("async_clear", '0);
    m = '0;
    #2;
    rst_a = 1'b1;
    step("inc_after_rst", 0, 1, 0, '0);
    step("inc_again", 0, 1, 0, '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
